// File: rtl/memory_responder.sv
// Memory-side responder: REM/RDM registers and a word RAM with a ready handshake
// for configurable read/write latency. Define MEMORY_RESPONDER_LOAD_EN for the program-preload port.
module memory_responder #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeREM,
  input  logic              selectREM,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              writeRDM,
  input  logic [1:0]        selectRDM,
  input  logic [DATA_W-1:0] ac_in,
  input  logic [DATA_W-1:0] in_in,
  input  logic              writeMEM,
`ifdef MEMORY_RESPONDER_LOAD_EN
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
`endif
  output logic [ADDR_W-1:0] rem_out,
  output logic [DATA_W-1:0] rdm_out,
  output logic              ready,
  output logic              protocol_err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  localparam logic [3:0] RD_CNT = (READ_LAT  > 0) ? 4'(READ_LAT  - 1) : 4'd0;
  localparam logic [3:0] WR_CNT = (WRITE_LAT > 0) ? 4'(WRITE_LAT - 1) : 4'd0;

  state_t            state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic [ADDR_W-1:0] rem, remNext, pendAddr, pendAddrNext;
  logic [DATA_W-1:0] rdm, rdmNext, pendData, pendDataNext;
  logic              err, errNext;
  logic              memWe;
  logic [ADDR_W-1:0] memWAddr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              loadReq;
  logic [ADDR_W-1:0] loadAddr;
  logic [DATA_W-1:0] loadData;
`ifdef MEMORY_RESPONDER_LOAD_EN
  assign loadReq  = load_en;
  assign loadAddr = load_addr;
  assign loadData = load_data;
`else
  assign loadReq  = 1'b0;
  assign loadAddr = '0;
  assign loadData = '0;
`endif

  logic anyStrobe;
  assign anyStrobe = writeREM | writeRDM | writeMEM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      rdm      <= '0;
      pendAddr <= '0;
      pendData <= '0;
      err      <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      rem      <= remNext;
      rdm      <= rdmNext;
      pendAddr <= pendAddrNext;
      pendData <= pendDataNext;
      err      <= errNext;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memWAddr] <= memWData;
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    remNext      = rem;
    rdmNext      = rdm;
    pendAddrNext = pendAddr;
    pendDataNext = pendData;
    errNext      = 1'b0;
    memWe        = 1'b0;
    memWAddr     = pendAddr;
    memWData     = pendData;
    unique case (state)
      IDLE: begin
        if (loadReq) begin
          memWe    = 1'b1;
          memWAddr = loadAddr;
          memWData = loadData;
          errNext  = anyStrobe;
        end else begin
          if (writeREM) remNext = selectREM ? pc_in : rdm[ADDR_W-1:0];
          // A write takes priority; any RDM load in the same cycle is dropped and flagged.
          if (writeMEM) begin
            errNext = writeRDM;
            if (WRITE_LAT == 0) begin
              memWe    = 1'b1;
              memWAddr = rem;
              memWData = rdm;
            end else begin
              stateNext    = WR_WAIT;
              cntNext      = WR_CNT;
              pendAddrNext = rem;
              pendDataNext = rdm;
            end
          end else if (writeRDM) begin
            case (selectRDM)
              2'b00: rdmNext = ac_in;
              2'b01: rdmNext = in_in;
              2'b10: begin
                if (READ_LAT == 0) begin
                  rdmNext = mem[rem];
                end else begin
                  stateNext    = RD_WAIT;
                  cntNext      = RD_CNT;
                  pendAddrNext = rem;
                end
              end
              default: errNext = 1'b1;
            endcase
          end
        end
      end
      RD_WAIT: begin
        errNext = anyStrobe;
        if (cnt == 4'd0) begin
          rdmNext   = mem[pendAddr];
          stateNext = IDLE;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      WR_WAIT: begin
        errNext = anyStrobe;
        if (cnt == 4'd0) begin
          memWe     = 1'b1;
          stateNext = IDLE;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (rst) memWe = 1'b0;
  end

  assign rem_out      = rem;
  assign rdm_out      = rdm;
  assign ready        = (state == IDLE) && !loadReq;
  assign protocol_err = err;

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
Memory-side responder for the accumulator processor's control unit. Holds the REM (address) and RDM (data) registers and a synchronous word RAM. Executes the control unit's per-T-state strobes (writeREM, writeRDM with selectRDM, writeMEM) with configurable read/write latency. Reports a ready handshake so the control unit can stall its T-state counter.

Parameters:
DATA_W, 8, word width of RDM, RAM, ac_in, in_in.
ADDR_W, 8, REM width; RAM depth is 2**ADDR_W.
READ_LAT, 2, extra wait cycles for a RAM read (0..15).
WRITE_LAT, 1, extra wait cycles for a RAM write (0..15).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
writeREM  in  1  load REM.
selectREM  in  1  REM source: 1 = pc_in, 0 = rdm_out[ADDR_W-1:0].
pc_in  in  ADDR_W  program counter value.
writeRDM  in  1  load RDM.
selectRDM  in  2  RDM source: 00 ac_in, 01 in_in, 10 RAM[REM], 11 reserved.
ac_in  in  DATA_W  accumulator value.
in_in  in  DATA_W  input-port value.
writeMEM  in  1  write RDM into RAM[REM].
rem_out  out  ADDR_W  current REM.
rdm_out  out  DATA_W  current RDM.
ready  out  1  1 = idle, strobes accepted this cycle.
protocol_err  out  1  one-cycle pulse on a rejected or illegal request.

Behaviour:
- Reset values: rem_out=0, rdm_out=0, ready=1, protocol_err=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Strobes are sampled only when ready=1. Any strobe while ready=0 is ignored and pulses protocol_err on the next cycle. REM, RDM and RAM are unchanged by the rejected strobe.
- writeREM: REM loads at the accepting edge. Zero latency; no effect on ready.
- writeRDM, sel 00/01: RDM loads ac_in / in_in at the accepting edge. Zero latency.
- writeRDM, sel 11: RDM holds and protocol_err pulses.
- Read (writeRDM, sel 10):
  - READ_LAT=0: RDM <= RAM[REM] at the accepting edge; ready stays 1.
  - READ_LAT>0: address is captured from the pre-edge REM. FSM goes IDLE->RD_WAIT, ready=0 for exactly READ_LAT cycles. RDM updates on the edge that returns the FSM to IDLE (ready=1 in the same cycle).
- Write (writeMEM): data/address are captured from the pre-edge RDM/REM.
  - WRITE_LAT=0: RAM updated at the accepting edge.
  - Otherwise: FSM goes IDLE->WR_WAIT, ready=0 for WRITE_LAT cycles, RAM updates on exit.
- Same-cycle combinations:
  - writeREM + read/write: the RAM operation uses the old REM; REM takes the new value.
  - writeMEM + writeRDM (any sel): the write proceeds with the old RDM, the RDM load is dropped, protocol_err pulses.
  - writeMEM + read: the write wins, the read is dropped, protocol_err pulses.
- Wait counter counts down from LAT-1 to 0; the exit edge is when the counter is 0.
- Address wrap: REM is ADDR_W bits; pc_in/rdm_out truncation is by bit slice. No out-of-range case.
- rst asserted mid-RD_WAIT/WR_WAIT: the FSM aborts to IDLE. A pending write is discarded (RAM unchanged); a pending read leaves RDM=0 per reset.

Optional Feature:
MEMORY_RESPONDER_LOAD_EN
- Defined: adds ports load_en (in 1), load_addr (in ADDR_W), load_data (in DATA_W) for program preload.
  - load_en=1 writes RAM[load_addr]<=load_data every cycle, zero latency.
  - load_en forces ready=0 and blocks all control strobes; a blocked strobe sets protocol_err.
  - load_en while the FSM is busy waits until IDLE before taking effect.
- Undefined: no load ports; RAM is initialised only by writeMEM.

Test Plan:
- Reset, then writeREM sel=1 pc_in=0x10, then writeRDM sel=00 ac_in=0xA5 -> rem_out=0x10 and rdm_out=0xA5 one cycle each, ready stays 1.
- writeMEM with REM=0x10, RDM=0xA5, WRITE_LAT=1; then ac load 0x00, then read sel=10 with READ_LAT=2 -> ready low 1 cycle for the write and 2 cycles for the read; rdm_out=0xA5 when ready rises.
- Read of RAM[0x10] issued with simultaneous writeREM pc_in=0x20 -> rdm_out=0xA5 (old address), rem_out=0x20.
- writeRDM sel=01 in_in=0x3C pulsed while ready=0 during a read -> protocol_err=1 for one cycle; rdm_out ends with the RAM data, not 0x3C.
- writeMEM+writeRDM sel=00 same cycle with RDM=0x11, ac_in=0x22 -> RAM[REM]=0x11, rdm_out stays 0x11, protocol_err pulses.
- rst during RD_WAIT (READ_LAT=3, cycle 2) -> next cycle ready=1, rdm_out=0, rem_out=0; RAM unchanged.
